// File: rtl/im_loader.sv
// Byte-stream program loader: assembles little-endian words and writes them into instruction RAM.
// Optional trailer checksum is enabled with the macro IM_LOADER_CHECKSUM_EN.
module im_loader #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 128,
    parameter int BASE_ADDR   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
`ifdef IM_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    // State entered once all words are written (or immediately for an empty image).
`ifdef IM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       idx_q, idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       len_next;
    logic              restart;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]        acc_q, acc_d;
    logic [7:0]        chk_sum;
`endif

    assign waddr = waddr_q;
    assign wdata = wdata_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
`ifdef IM_LOADER_CHECKSUM_EN
        acc_d      = acc_q;
        chk_sum    = acc_q + in_data;
`endif
        in_ready   = 1'b0;
        we         = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_hold   = 1'b1;
        restart    = 1'b0;
        len_next   = {in_data, len_q[7:0]};

        case (state_q)
            S_IDLE: begin
                cpu_hold = 1'b0;
                restart  = start;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                restart  = start;
            end
            S_ERROR: begin
                error   = 1'b1;
                restart = start;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    len_d      = len_next;
                    byte_cnt_d = 2'd0;
                    if (len_next == 16'd0)
                        state_d = S_TAIL;
                    else if (32'(len_next) > DEPTH_WORDS)
                        state_d = S_ERROR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef IM_LOADER_CHECKSUM_EN
                    acc_d = chk_sum;
`endif
                    // Lane 3 completes the word; the write goes out next cycle from the registers.
                    case (byte_cnt_q)
                        2'd0: asm_d[7:0]   = in_data;
                        2'd1: asm_d[15:8]  = in_data;
                        2'd2: asm_d[23:16] = in_data;
                        default: begin
                            wdata_d = {in_data, asm_q};
                            waddr_d = BASE_A + ADDR_W'({idx_q, 2'b00});
                            state_d = S_WRITE;
                        end
                    endcase
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end
            S_WRITE: begin
                we    = 1'b1;
                idx_d = idx_q + 16'd1;
                if (idx_q == len_q - 16'd1)
                    state_d = S_TAIL;
                else
                    state_d = S_DATA;
            end
`ifdef IM_LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_d = (chk_sum == 8'h00) ? S_DONE : S_ERROR;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (restart) begin
            state_d    = S_LEN_LO;
            idx_d      = 16'd0;
            byte_cnt_d = 2'd0;
`ifdef IM_LOADER_CHECKSUM_EN
            acc_d      = 8'h00;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            acc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
`ifdef IM_LOADER_CHECKSUM_EN
            acc_q      <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: table vectors, hand-written corner sequences and
// randomized loads checked against a stream-parsing reference model.
module tb_im_loader;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 128;
    localparam int BASE   = 0;
`ifdef IM_LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, start, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, we, cpu_hold, done, error;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;

    im_loader #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [47:0] got_q[$];
    int          got_cyc[$];
    logic [47:0] exp_q[$];
    logic [7:0]  stim_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (we) begin
                got_q.push_back({waddr, wdata});
                got_cyc.push_back(cyc);
            end
            n_checks++;
            if (done && error) begin
                n_fail++;
                $display("FAIL done_error_exclusive: done=%0b error=%0b required not both", done, error);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            tick(1);
            waited++;
        end
        if (waited >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
        end
        tick(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("start_cpu_hold", cpu_hold, 1);
        check("start_done_clr", done, 0);
        check("start_err_clr", error, 0);
        check("start_in_ready", in_ready, 1);
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic apply_stim(input bit stalls);
        foreach (stim_q[i]) begin
            if (stalls && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick($urandom_range(1, 3));
            end
            send_byte(stim_q[i]);
        end
        in_valid = 1'b0;
        tick(4);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_write"}, got_q[i], exp_q[i]);
    endtask

    task automatic check_outcome(input string tag, input bit ok);
        check({tag, "_done"}, done, ok);
        check({tag, "_error"}, error, !ok);
        check({tag, "_cpu_hold"}, cpu_hold, !ok);
    endtask

    // Reference: parse the byte stream by its format rules.
    task automatic model(output bit ok);
        int n;
        logic [7:0] sum;
        logic [31:0] w;
        exp_q.delete();
        n  = int'(stim_q[0]) + 256 * int'(stim_q[1]);
        ok = 1'b1;
        if (n > DEPTH) begin
            ok = 1'b0;
            return;
        end
        sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = 0;
            for (int k = 0; k < 4; k++) begin
                w   = w + (32'(stim_q[2 + 4*i + k]) << (8*k));
                sum = sum + stim_q[2 + 4*i + k];
            end
            exp_q.push_back({16'(BASE + 4*i), w});
        end
        if (CHK) ok = ((sum + stim_q[2 + 4*n]) == 8'h00);
    endtask

    task automatic gen_stream(input int n, input bit corrupt);
        logic [7:0] sum = 8'h00;
        logic [7:0] b;
        stim_q.delete();
        stim_q.push_back(8'(n));
        stim_q.push_back(8'(n >> 8));
        if (n > DEPTH) return;
        for (int i = 0; i < 4*n; i++) begin
            b = 8'($urandom);
            sum = sum + b;
            stim_q.push_back(b);
        end
        if (CHK) stim_q.push_back((8'h00 - sum) ^ (corrupt ? 8'(1 + $urandom_range(0, 254)) : 8'h00));
    endtask

    typedef struct {
        int          nb;
        logic [7:0]  b [0:11];
        bit          has_trl;
        logic [7:0]  trl;
        int          nw;
        logic [31:0] w [0:1];
        bit          exp_done;
    } vec_t;

    vec_t vt[0:5];
    int   nvec;

    task automatic run_vec(input int v);
        pulse_start();
        stim_q.delete();
        for (int i = 0; i < vt[v].nb; i++) stim_q.push_back(vt[v].b[i]);
        if (CHK && vt[v].has_trl) stim_q.push_back(vt[v].trl);
        apply_stim(1'b0);
        exp_q.delete();
        for (int i = 0; i < vt[v].nw; i++) exp_q.push_back({16'(BASE + 4*i), vt[v].w[i]});
        check_writes("vec");
        check_outcome("vec", vt[v].exp_done);
        if (got_cyc.size() == 2) check("vec_throughput", got_cyc[1] - got_cyc[0], 5);
    endtask

    initial begin
        bit ok;
        int n;

        vt[0] = '{10, '{8'h02, 8'h00, 8'h93, 8'h02, 8'h80, 8'h02, 8'h73, 8'h90, 8'h52, 8'h00, 8'h00, 8'h00},
                  1'b1, 8'h94, 2, '{32'h02800293, 32'h00529073}, 1'b1};
        vt[1] = '{2, '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  1'b0, 8'h00, 0, '{32'h0, 32'h0}, 1'b0};
        vt[2] = '{2, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  1'b1, 8'h00, 0, '{32'h0, 32'h0}, 1'b1};
        vt[3] = '{6, '{8'h01, 8'h00, 8'h13, 8'h03, 8'hB0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  1'b1, 8'h3A, 1, '{32'h00B00313, 32'h0}, 1'b1};
        vt[4] = '{2, '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  1'b0, 8'h00, 0, '{32'h0, 32'h0}, 1'b0};
        nvec = 5;
`ifdef IM_LOADER_CHECKSUM_EN
        vt[5] = '{6, '{8'h01, 8'h00, 8'h13, 8'h03, 8'hB0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  1'b1, 8'h3B, 1, '{32'h00B00313, 32'h0}, 1'b0};
        nvec = 6;
`endif

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tick(3);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 0);
        check("rst_we", we, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);

        for (int v = 0; v < nvec; v++) run_vec(v);

        // Stall for 3 cycles mid-word, and check the write lands the cycle after byte 4.
        pulse_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h93); send_byte(8'h02);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("stall_in_ready", in_ready, 1);
            check("stall_no_we", we, 0);
        end
        send_byte(8'h80); send_byte(8'h02);
        check("latency_we", we, 1);
        check("latency_waddr", waddr, 16'h0000);
        check("latency_wdata", wdata, 32'h02800293);
        send_byte(8'h73); send_byte(8'h90); send_byte(8'h52); send_byte(8'h00);
        if (CHK) send_byte(8'h94);
        in_valid = 1'b0;
        tick(4);
        exp_q.delete();
        exp_q.push_back({16'h0000, 32'h02800293});
        exp_q.push_back({16'h0004, 32'h00529073});
        check_writes("stall");
        check_outcome("stall", 1'b1);

        // Reset partway through word 0 aborts without writing.
        pulse_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h93); send_byte(8'h02);
        in_valid = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("abort_nwrites", got_q.size(), 0);
        check("abort_cpu_hold", cpu_hold, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_done", done, 0);
        run_vec(3);

        // start while busy is ignored.
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h13); send_byte(8'h03);
        in_valid = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("busy_in_ready", in_ready, 1);
        check("busy_cpu_hold", cpu_hold, 1);
        send_byte(8'hB0); send_byte(8'h00);
        if (CHK) send_byte(8'h3A);
        in_valid = 1'b0;
        tick(4);
        exp_q.delete();
        exp_q.push_back({16'h0000, 32'h00B00313});
        check_writes("busy");
        check_outcome("busy", 1'b1);

        // Full-capacity image, then randomized loads with random stalls.
        for (int k = 0; k < 15; k++) begin
            if (k == 0) n = DEPTH;
            else if ($urandom_range(0, 9) < 7) n = $urandom_range(0, 6);
            else n = $urandom_range(DEPTH + 1, 600);
            gen_stream(n, CHK && ($urandom_range(0, 3) == 0));
            model(ok);
            pulse_start();
            apply_stim(1'b1);
            check_writes("rand");
            check_outcome("rand", ok);
            if (k == 0 && got_q.size() == DEPTH)
                check("max_last_waddr", got_q[DEPTH-1][47:32], 16'(BASE + 4*(DEPTH-1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer-side counterpart of the instruction memory: receives a program as a byte stream and writes it, one 32-bit word at a time, into a writable instruction memory.
- Sits between a host byte source (UART receiver or testbench) and the instruction RAM write port.
- Holds the CPU in reset (cpu_hold) while loading; releases it once the image is complete and valid.
- Word addresses are byte addresses stepping by 4, matching the fetch side (addr >> 2 indexing).

Parameters:
- ADDR_W, 16, width of the byte address driven on waddr.
- DEPTH_WORDS, 128, capacity of the instruction memory in 32-bit words; larger images are rejected.
- BASE_ADDR, 0, byte address of the first written word; must be a multiple of 4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; ignored unless state is IDLE, DONE or ERROR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready.
- we  out  1  instruction memory write enable, asserted for exactly one cycle per word.
- waddr  out  ADDR_W  byte address of the word being written.
- wdata  out  32  word being written.
- cpu_hold  out  1  holds the CPU in reset while high.
- done  out  1  high while the last load completed successfully.
- error  out  1  high while the last load was rejected.

Behaviour:
- Reset: state = IDLE; in_ready, we, done, error and cpu_hold = 0; waddr, wdata and the internal counters = 0. Any partial word is discarded and no write is issued.

Stream format:
- 2-byte little-endian word count N.
- Then N words, each sent as 4 bytes, least significant byte first (byte0 goes to wdata[7:0]).
- Then a checksum byte, only when CHECKSUM_EN is defined.

States:
- IDLE: in_ready = 0. On start, go to LEN_LO, clear the word index, byte counter and checksum accumulator, and set cpu_hold = 1.
- LEN_LO / LEN_HI: in_ready = 1; on each transfer, capture N[7:0] then N[15:8]. Leaving LEN_HI:
  - N == 0: go to DONE (or CHK if enabled).
  - N > DEPTH_WORDS: go to ERROR.
  - otherwise: go to DATA.
- DATA: in_ready = 1. Shift each transferred byte into the assembly register at lane byte_cnt. On the 4th byte, go to WRITE.
- WRITE: in_ready = 0. For one cycle drive we = 1, waddr = BASE_ADDR + 4*idx, wdata = the assembled word; then idx++.
  - Last word (idx == N-1): go to DONE, or CHK if enabled.
  - Otherwise: return to DATA.
- DONE: done = 1, cpu_hold = 0, in_ready = 0. Stays here until start or rst.
- ERROR: error = 1, cpu_hold = 1, in_ready = 0. Stays here until start or rst.

Outputs and timing:
- done and error are cleared on start. They are never high together.
- waddr and wdata are held stable outside WRITE; they are only meaningful while we = 1.
- Latency: the write occurs the cycle after the 4th byte transfer. With in_valid tied high, sustained throughput is 1 word per 5 cycles.

Boundary conditions:
- in_valid low stalls with no timeout; partial state is retained.
- start while busy (LEN_LO, LEN_HI, DATA, WRITE, CHK) is ignored.
- rst mid-load aborts immediately: no write, cpu_hold = 0.
- N == DEPTH_WORDS is legal; the last waddr is BASE_ADDR + 4*(DEPTH_WORDS-1).
- Index and address arithmetic wraps modulo 2^ADDR_W; no other wrap occurs.

Optional Feature:
- Macro: IM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit accumulator sums every data byte (not the length bytes) mod 256.
  - After the last WRITE (or right after LEN_HI when N == 0), the CHK state (in_ready = 1) accepts one trailer byte.
  - If accumulator + trailer == 8'h00, go to DONE; otherwise go to ERROR. Words already written remain in memory, and cpu_hold stays 1.
- Undefined: no CHK state, no trailer byte, no accumulator logic; the last WRITE goes directly to DONE.

Test Plan:
- Reset, pulse start, stream 02 00 93 02 80 02 73 90 52 00 -> we pulses twice: (waddr 0x0000, wdata 0x02800293), then (0x0004, 0x00529073); then done = 1, cpu_hold = 0.
- Same stream with in_valid dropped for 3 cycles mid-word -> in_ready remains 1, no extra or early we, identical writes.
- Count bytes 81 00 (N = 129 > 128) -> ERROR, error = 1, cpu_hold = 1, no we; a subsequent start plus a valid 1-word stream -> done = 1, error = 0.
- Count 00 00 -> no we, done = 1 (with CHECKSUM_EN, the trailer 00 is required first).
- rst asserted after 2 data bytes of word 0 -> no we; state IDLE, cpu_hold = 0; a new load then writes word 0 at 0x0000 correctly.
- CHECKSUM_EN, one word 13 03 B0 00 (sum 0xC6): trailer 3A -> done = 1; trailer 3B -> error = 1, cpu_hold = 1.
